enemy_hit_sched: RTL and testbench

Time-multiplexed collision scheduler for the enemy formation. Once per frame it walks all N enemies through a single shared hit-box comparator against both ship missiles, keeps the alive bitmap that gates enemy drawing, and retires missiles that hit. It replaces one comparator per enemy and sits between the missile and formation-position logic and the enemy draw chain.

---
 rtl/enemy_pkg.sv | 19 +
 rtl/enemy_hit_sched_hit_box_cmp.sv | 42 ++++
 rtl/enemy_hit_sched.sv | 192 +++++++++++++++++++
 tb/tb_enemy_hit_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared enemy geometry constants and scheduler state encoding
//
// Purpose: constants shared between the collision scheduler and the enemy draw
// chain, plus the three-state FSM encoding used by enemy_hit_sched.
// Ports: none (package).
package enemy_pkg;

    localparam int COORD_W          = 11;
    localparam int CMP_W            = 12;
    localparam int HALF_WIDTH_ENEMY = 25;
    localparam int HEIGHT_ENEMY     = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/enemy_hit_sched_hit_box_cmp.sv
// rtl/enemy_hit_sched_hit_box_cmp.sv - combinational enemy/missile hit-box comparator
//
// Purpose: decides whether a missile point lies inside one enemy's hit box.
// Ports:
//   xe, ye  - enemy x centre and top edge
//   xm, ym  - missile position
//   valid   - qualifier (enemy alive, missile in flight, missile not yet used)
//   hit     - missile inside the box and valid
module hit_box_cmp
    import enemy_pkg::*;
(
    input  logic [COORD_W-1:0] xe,
    input  logic [COORD_W-1:0] ye,
    input  logic [COORD_W-1:0] xm,
    input  logic [COORD_W-1:0] ym,
    input  logic               valid,
    output logic               hit
);

    logic [CMP_W-1:0] xe_w;
    logic [CMP_W-1:0] ye_w;
    logic [CMP_W-1:0] xm_w;
    logic [CMP_W-1:0] ym_w;
    logic [CMP_W-1:0] left;
    logic [CMP_W-1:0] right;
    logic [CMP_W-1:0] bottom;

    // One extra bit of headroom means the right and bottom bounds cannot
    // overflow; the left bound is clamped at 0 instead of wrapping.
    always_comb begin
        xe_w   = {1'b0, xe};
        ye_w   = {1'b0, ye};
        xm_w   = {1'b0, xm};
        ym_w   = {1'b0, ym};
        left   = (xe_w >= CMP_W'(HALF_WIDTH_ENEMY)) ? (xe_w - CMP_W'(HALF_WIDTH_ENEMY)) : '0;
        right  = xe_w + CMP_W'(HALF_WIDTH_ENEMY);
        bottom = ye_w + CMP_W'(HEIGHT_ENEMY);
        hit    = valid && (xm_w >= left) && (xm_w <= right)
                       && (ym_w >= ye_w) && (ym_w <= bottom);
    end

endmodule

// File: rtl/enemy_hit_sched.sv
// rtl/enemy_hit_sched.sv - time-multiplexed enemy collision scheduler
//
// Purpose: once per frame walks all N enemies through one shared hit-box
// comparator per missile, maintains the alive bitmap and retires missiles.
// Optional build macro: ENEMY_HIT_SCORE_EN adds a saturating kill counter.
// Ports:
//   pclk, rst (sync, active low)   - clock and reset
//   frame_tick                     - starts a scan when idle
//   level_change                   - revives all enemies, aborts a scan
//   xpos_enemy, ypos_enemy         - packed 11-bit enemy positions
//   xpos/ypos/missile_valid_1/_2   - missile positions and in-flight flags
//   enemy_on                       - alive bitmap
//   hit_missile_1/_2               - retire pulses
//   kill_valid, kill_idx           - kill report pulse and enemy index
//   score (optional)               - saturating kill count
//   busy                           - scan in progress
//   level_clear                    - all enemies dead (registered)
module enemy_hit_sched
    import enemy_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 5
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   level_change,
    input  logic [11*N-1:0]        xpos_enemy,
    input  logic [11*N-1:0]        ypos_enemy,
    input  logic [COORD_W-1:0]     xpos_missile_1,
    input  logic [COORD_W-1:0]     ypos_missile_1,
    input  logic                   missile_valid_1,
    input  logic [COORD_W-1:0]     xpos_missile_2,
    input  logic [COORD_W-1:0]     ypos_missile_2,
    input  logic                   missile_valid_2,
    output logic [N-1:0]           enemy_on,
    output logic                   hit_missile_1,
    output logic                   hit_missile_2,
    output logic                   kill_valid,
    output logic [IDX_W-1:0]       kill_idx,
`ifdef ENEMY_HIT_SCORE_EN
    output logic [15:0]            score,
`endif
    output logic                   busy,
    output logic                   level_clear
);

    sched_state_t state;
    sched_state_t state_next;

    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
    logic               v1_q, v2_q;
    logic               used1, used2;

    logic [COORD_W-1:0] xe_cur;
    logic [COORD_W-1:0] ye_cur;
    logic               alive_cur;
    logic [N-1:0]       idx_onehot;
    logic               last_idx;
    logic               scanning;
    logic               hit_now_1;
    logic               hit_now_2;
    logic               kill_now;

    // Explicit mux over the enemy buses keeps every select in range even
    // though idx is wider than clog2(N).
    always_comb begin
        xe_cur     = '0;
        ye_cur     = '0;
        alive_cur  = 1'b0;
        idx_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                xe_cur        = xpos_enemy[11*k +: 11];
                ye_cur        = ypos_enemy[11*k +: 11];
                alive_cur     = enemy_on[k];
                idx_onehot[k] = 1'b1;
            end
        end
    end

    assign scanning = (state == ST_SCAN);
    assign last_idx = (idx == IDX_W'(N - 1));

    hit_box_cmp u_cmp_1 (
        .xe    (xe_cur),
        .ye    (ye_cur),
        .xm    (x1_q),
        .ym    (y1_q),
        .valid (scanning && alive_cur && v1_q && !used1),
        .hit   (hit_now_1)
    );

    hit_box_cmp u_cmp_2 (
        .xe    (xe_cur),
        .ye    (ye_cur),
        .xm    (x2_q),
        .ym    (y2_q),
        .valid (scanning && alive_cur && v2_q && !used2),
        .hit   (hit_now_2)
    );

    // Only one enemy is compared per cycle, so a double hit is a single kill.
    assign kill_now = hit_now_1 || hit_now_2;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (frame_tick) state_next = ST_SCAN;
            ST_SCAN: if (last_idx)   state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (level_change) state_next = ST_IDLE;
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            x2_q          <= '0;
            y2_q          <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            used1         <= 1'b0;
            used2         <= 1'b0;
            enemy_on      <= '1;
            hit_missile_1 <= 1'b0;
            hit_missile_2 <= 1'b0;
            kill_valid    <= 1'b0;
            kill_idx      <= '0;
            level_clear   <= 1'b0;
        end else begin
            state         <= state_next;
            hit_missile_1 <= 1'b0;
            hit_missile_2 <= 1'b0;
            kill_valid    <= 1'b0;
            level_clear   <= (enemy_on == '0);
            if (level_change) begin
                enemy_on <= '1;
                used1    <= 1'b0;
                used2    <= 1'b0;
                idx      <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            x1_q  <= xpos_missile_1;
                            y1_q  <= ypos_missile_1;
                            v1_q  <= missile_valid_1;
                            x2_q  <= xpos_missile_2;
                            y2_q  <= ypos_missile_2;
                            v2_q  <= missile_valid_2;
                            used1 <= 1'b0;
                            used2 <= 1'b0;
                            idx   <= '0;
                        end
                    end
                    ST_SCAN: begin
                        if (kill_now) begin
                            enemy_on      <= enemy_on & ~idx_onehot;
                            kill_valid    <= 1'b1;
                            kill_idx      <= idx;
                            hit_missile_1 <= hit_now_1;
                            hit_missile_2 <= hit_now_2;
                            used1         <= used1 || hit_now_1;
                            used2         <= used2 || hit_now_2;
                        end
                        idx <= last_idx ? '0 : idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ENEMY_HIT_SCORE_EN
    // Survives level_change; only reset clears it.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            score <= '0;
        end else if (kill_now && !level_change && (score != 16'hFFFF)) begin
            score <= score + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enemy_hit_sched.sv
// tb/tb_enemy_hit_sched.sv - self-checking bench for enemy_hit_sched
module tb_enemy_hit_sched;

    localparam int N     = 8;
    localparam int IDX_W = 5;

    logic              pclk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_tick = 1'b0;
    logic              level_change = 1'b0;
    logic [11*N-1:0]   xpos_enemy;
    logic [11*N-1:0]   ypos_enemy;
    logic [10:0]       xm1, ym1, xm2, ym2;
    logic              mv1 = 1'b0;
    logic              mv2 = 1'b0;
    logic [N-1:0]      enemy_on;
    logic              hit_missile_1, hit_missile_2, kill_valid, busy, level_clear;
    logic [IDX_W-1:0]  kill_idx;
`ifdef ENEMY_HIT_SCORE_EN
    logic [15:0]       score;
`endif

    enemy_hit_sched #(.N(N), .IDX_W(IDX_W)) dut (
        .pclk            (pclk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .level_change    (level_change),
        .xpos_enemy      (xpos_enemy),
        .ypos_enemy      (ypos_enemy),
        .xpos_missile_1  (xm1),
        .ypos_missile_1  (ym1),
        .missile_valid_1 (mv1),
        .xpos_missile_2  (xm2),
        .ypos_missile_2  (ym2),
        .missile_valid_2 (mv2),
        .enemy_on        (enemy_on),
        .hit_missile_1   (hit_missile_1),
        .hit_missile_2   (hit_missile_2),
        .kill_valid      (kill_valid),
        .kill_idx        (kill_idx),
`ifdef ENEMY_HIT_SCORE_EN
        .score           (score),
`endif
        .busy            (busy),
        .level_clear     (level_clear)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int ia, xa, ya, ib, xb, yb;
        int x1, y1, v1, x2, y2, v2;
        int e_kills, e_idx, e_h1, e_h2, e_on;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_enemy(input int k, input int x, input int y);
        xpos_enemy[11*k +: 11] = 11'(x);
        ypos_enemy[11*k +: 11] = 11'(y);
    endtask

    task automatic clear_field();
        for (int k = 0; k < N; k++) set_enemy(k, 1800, 1800);
        xm1 = '0; ym1 = '0; mv1 = 1'b0;
        xm2 = '0; ym2 = '0; mv2 = 1'b0;
    endtask

    task automatic revive();
        level_change = 1'b1;
        step();
        level_change = 1'b0;
    endtask

    task automatic run_scan(output int kills, output int first_idx, output int first_cyc,
                            output int h1, output int h2, output int busy_cnt);
        kills = 0; first_idx = -1; first_cyc = -1; h1 = 0; h2 = 0; busy_cnt = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 1; c <= N + 4; c++) begin
            if (kill_valid) begin
                if (kills == 0) begin
                    first_idx = int'(kill_idx);
                    first_cyc = c;
                end
                kills++;
            end
            if (hit_missile_1) h1++;
            if (hit_missile_2) h2++;
            if (busy) busy_cnt++;
            step();
        end
    endtask

    int kills, fidx, fcyc, h1, h2, bcnt, zero_c, lc_c;

    initial begin
        vecs[0]  = '{3, 200, 100, 3, 200, 100, 210, 120, 1, 0, 0, 0, 1, 3, 1, 0, 'hF7};
        vecs[1]  = '{0, 10, 100, 0, 10, 100, 0, 110, 1, 0, 0, 0, 1, 0, 1, 0, 'hFE};
        vecs[2]  = '{0, 30, 100, 0, 30, 100, 4, 110, 1, 0, 0, 0, 0, -1, 0, 0, 'hFF};
        vecs[3]  = '{2, 200, 100, 2, 200, 100, 205, 110, 1, 205, 110, 1, 1, 2, 1, 1, 'hFB};
        vecs[4]  = '{1, 200, 100, 4, 200, 100, 200, 100, 1, 0, 0, 0, 1, 1, 1, 0, 'hFD};
        vecs[5]  = '{5, 300, 200, 5, 300, 200, 0, 0, 0, 325, 250, 1, 1, 5, 0, 1, 'hDF};
        vecs[6]  = '{5, 300, 200, 5, 300, 200, 0, 0, 0, 326, 200, 1, 0, -1, 0, 0, 'hFF};
        vecs[7]  = '{1, 100, 100, 1, 100, 100, 100, 100, 0, 0, 0, 0, 0, -1, 0, 0, 'hFF};
        vecs[8]  = '{4, 400, 300, 4, 400, 300, 400, 299, 1, 0, 0, 0, 0, -1, 0, 0, 'hFF};
        vecs[9]  = '{1, 100, 100, 6, 600, 100, 100, 100, 1, 600, 150, 1, 2, 1, 1, 1, 'hBD};
        vecs[10] = '{7, 1000, 1000, 7, 1000, 1000, 975, 1000, 1, 0, 0, 0, 1, 7, 1, 0, 'h7F};

        // reset values
        clear_field();
        rst = 1'b0;
        step();
        step();
        check("reset enemy_on", 32'(enemy_on), 32'hFF);
        check("reset kill_valid", 32'(kill_valid), 0);
        check("reset kill_idx", 32'(kill_idx), 0);
        check("reset hits", 32'({hit_missile_1, hit_missile_2}), 0);
        check("reset busy", 32'(busy), 0);
        check("reset level_clear", 32'(level_clear), 0);
        rst = 1'b1;
        step();

        // table-driven single-scan vectors
        for (int v = 0; v < 11; v++) begin
            clear_field();
            set_enemy(vecs[v].ia, vecs[v].xa, vecs[v].ya);
            set_enemy(vecs[v].ib, vecs[v].xb, vecs[v].yb);
            xm1 = 11'(vecs[v].x1); ym1 = 11'(vecs[v].y1); mv1 = (vecs[v].v1 != 0);
            xm2 = 11'(vecs[v].x2); ym2 = 11'(vecs[v].y2); mv2 = (vecs[v].v2 != 0);
            revive();
            run_scan(kills, fidx, fcyc, h1, h2, bcnt);
            check($sformatf("v%0d kills", v), 32'(kills), 32'(vecs[v].e_kills));
            check($sformatf("v%0d kill_idx", v), 32'(fidx), 32'(vecs[v].e_idx));
            if (vecs[v].e_kills > 0)
                check($sformatf("v%0d kill latency", v), 32'(fcyc), 32'(vecs[v].e_idx + 2));
            check($sformatf("v%0d hit1", v), 32'(h1), 32'(vecs[v].e_h1));
            check($sformatf("v%0d hit2", v), 32'(h2), 32'(vecs[v].e_h2));
            check($sformatf("v%0d busy cycles", v), 32'(bcnt), 32'(N + 1));
            check($sformatf("v%0d enemy_on", v), 32'(enemy_on), 32'(vecs[v].e_on));
        end

        // level_change during a scan, coinciding with a hit on enemy 2
        clear_field();
        set_enemy(0, 500, 500); xm2 = 11'd500; ym2 = 11'd510; mv2 = 1'b1;
        set_enemy(2, 200, 100); xm1 = 11'd205; ym1 = 11'd110; mv1 = 1'b1;
        revive();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("lc pre kill_valid", 32'(kill_valid), 1);
        check("lc pre enemy_on", 32'(enemy_on), 32'hFE);
        step();
        level_change = 1'b1;
        step();
        level_change = 1'b0;
        check("lc kill_valid", 32'(kill_valid), 0);
        check("lc hit1", 32'(hit_missile_1), 0);
        check("lc enemy_on", 32'(enemy_on), 32'hFF);
        check("lc busy", 32'(busy), 0);
        kills = 0; bcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (kill_valid) kills++;
            if (busy) bcnt++;
            step();
        end
        check("lc later kills", 32'(kills), 0);
        check("lc later busy", 32'(bcnt), 0);
        frame_tick = 1'b1;
        level_change = 1'b1;
        step();
        frame_tick = 1'b0;
        level_change = 1'b0;
        check("lc beats tick", 32'(busy), 0);

        // frame_tick during SCAN and during DONE is ignored
        clear_field();
        set_enemy(7, 1000, 1000); xm1 = 11'd1000; ym1 = 11'd1000; mv1 = 1'b1;
        revive();
        kills = 0; bcnt = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 1; c <= 3 * N; c++) begin
            if (kill_valid) kills++;
            if (busy) bcnt++;
            frame_tick = (c == 3 || c == N + 1);
            step();
        end
        frame_tick = 1'b0;
        check("retick busy cycles", 32'(bcnt), 32'(N + 1));
        check("retick kills", 32'(kills), 1);

        // kill all enemies over four scans, watch level_clear lag
        clear_field();
        for (int k = 0; k < 4; k++) set_enemy(k, 200, 100);
        for (int k = 4; k < 8; k++) set_enemy(k, 800, 100);
        xm1 = 11'd200; ym1 = 11'd100; mv1 = 1'b1;
        xm2 = 11'd800; ym2 = 11'd100; mv2 = 1'b1;
        revive();
        for (int s = 0; s < 3; s++) run_scan(kills, fidx, fcyc, h1, h2, bcnt);
        check("clear 3 scans enemy_on", 32'(enemy_on), 32'h88);
        check("clear 3 scans level_clear", 32'(level_clear), 0);
        zero_c = -1; lc_c = -1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int c = 1; c <= N + 4; c++) begin
            if (enemy_on == '0 && zero_c < 0) zero_c = c;
            if (level_clear && lc_c < 0) lc_c = c;
            step();
        end
        check("clear last kill cycle", 32'(zero_c), 9);
        check("clear level_clear cycle", 32'(lc_c), 10);
        revive();
        step();
        check("revive enemy_on", 32'(enemy_on), 32'hFF);
        check("revive level_clear", 32'(level_clear), 0);

        // reset in the middle of a scan
        clear_field();
        set_enemy(1, 500, 500); xm2 = 11'd500; ym2 = 11'd510; mv2 = 1'b1;
        set_enemy(4, 200, 100); xm1 = 11'd200; ym1 = 11'd100; mv1 = 1'b1;
        revive();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        check("rst pre kill_idx", 32'(kill_idx), 1);
        check("rst pre enemy_on", 32'(enemy_on), 32'hFD);
        rst = 1'b0;
        step();
        check("rst enemy_on", 32'(enemy_on), 32'hFF);
        check("rst kill_valid", 32'(kill_valid), 0);
        check("rst kill_idx", 32'(kill_idx), 0);
        check("rst hits", 32'({hit_missile_1, hit_missile_2}), 0);
        check("rst busy", 32'(busy), 0);
        check("rst level_clear", 32'(level_clear), 0);
        rst = 1'b1;
        kills = 0; bcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (kill_valid) kills++;
            if (busy) bcnt++;
            step();
        end
        check("rst later kills", 32'(kills), 0);
        check("rst later busy", 32'(bcnt), 0);

`ifdef ENEMY_HIT_SCORE_EN
        check("score after reset", 32'(score), 0);
        clear_field();
        set_enemy(0, 200, 100);
        set_enemy(4, 200, 100);
        set_enemy(5, 800, 100);
        xm1 = 11'd200; ym1 = 11'd100; mv1 = 1'b1;
        xm2 = 11'd800; ym2 = 11'd100; mv2 = 1'b1;
        revive();
        run_scan(kills, fidx, fcyc, h1, h2, bcnt);
        run_scan(kills, fidx, fcyc, h1, h2, bcnt);
        check("score 3 kills", 32'(score), 3);
        revive();
        step();
        check("score kept over level_change", 32'(score), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
